// File: rtl/modulation_sampler_if.sv
// Bus between the modulation sampler, its BRAM read port and the modulation multiplier.
// Handshake: START is a one-cycle request with M already stable; M stays put until the multiplier answers with a one-cycle DONE.
interface modulation_sampler_if #(
  parameter int ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [7:0]            DATA;
  logic [7:0]            M;
  logic                  START;
  logic                  DONE;

  modport master (
    output ADDR,
    input  DATA,
    output M,
    output START,
    input  DONE
  );

  modport slave (
    input  ADDR,
    output DATA,
    input  M,
    input  START,
    output DONE
  );
endinterface

// File: rtl/modulation_sampler.sv
// Fetches one modulation sample per UPDATE tick from BRAM and hands it to the
// multiplier over the START/M/DONE handshake, stepping the index every FREQ_DIV ticks.
module modulation_sampler #(
  parameter int ADDR_WIDTH = 15,
  parameter int DIV_WIDTH  = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  UPDATE,
  input  logic [ADDR_WIDTH-1:0] CYCLE,
  input  logic [DIV_WIDTH-1:0]  FREQ_DIV,
  modulation_sampler_if.master  bus,
  output logic [ADDR_WIDTH-1:0] IDX,
  output logic                  BUSY,
  output logic                  OVERRUN,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LATCH     = 3'd2,
    STROBE    = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  // A single-cycle BRAM needs no FETCH wait, so IDLE jumps straight to LATCH.
  localparam int     FETCH_LAST = (RD_LATENCY >= 2) ? RD_LATENCY - 2 : 0;
  localparam state_t AFTER_IDLE = (RD_LATENCY <= 1) ? LATCH : FETCH;

  state_t               state;
  logic [7:0]           fetch_cnt;
  logic [DIV_WIDTH-1:0] tick_cnt;
  logic [DIV_WIDTH-1:0] div_last;
  logic                 tick_wrap;
  logic [ADDR_WIDTH-1:0] idx_next;

  always_comb begin
    div_last  = (FREQ_DIV == '0) ? '0 : FREQ_DIV - 1'b1;
    tick_wrap = (tick_cnt >= div_last);
    // >= so an index left beyond a shrunken CYCLE wraps on its next advance.
    idx_next  = (IDX >= CYCLE) ? '0 : IDX + 1'b1;
  end

  assign BUSY      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      fetch_cnt <= '0;
      tick_cnt  <= '0;
      IDX       <= '0;
      OVERRUN   <= 1'b0;
      bus.ADDR  <= '0;
      bus.M     <= '0;
      bus.START <= 1'b0;
    end else begin
      bus.START <= 1'b0;

      // Tick bookkeeping runs on every UPDATE so sample timing survives an overrun.
      if (UPDATE) begin
        if (tick_wrap) begin
          tick_cnt <= '0;
          IDX      <= idx_next;
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
        if (state != IDLE) begin
          OVERRUN <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (UPDATE) begin
            bus.ADDR  <= IDX;
            fetch_cnt <= '0;
            state     <= AFTER_IDLE;
          end
        end
        FETCH: begin
          if (fetch_cnt >= 8'(FETCH_LAST)) begin
            state <= LATCH;
          end else begin
            fetch_cnt <= fetch_cnt + 1'b1;
          end
        end
        LATCH: begin
          bus.M <= bus.DATA;
          state <= STROBE;
        end
        STROBE: begin
          bus.START <= 1'b1;
          state     <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.DONE) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
